alu_op_decoder: RTL and testbench
=================================

# alu_op_decoder

Registered decode stage that sits on the driving end of the ALU select interface. It accepts 32-bit RV32I instructions over a valid/ready handshake and decodes opcode/funct3/funct7 into the 4-bit ALU select code, an immediate-operand flag and an illegal-instruction flag. A 2-entry skid buffer gives full throughput with fully registered outputs. The ALU consumes `ALU_Sel` and the operand-B mux consumes `use_imm`.

## Interface
- `WIDTH`, default 32: instruction width. Only 32 is supported.
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: synchronous, active-low reset. It is sampled on the `clk` rising edge.
- `flush`, input, 1: synchronous flush. It drops all buffered entries and any same-cycle input.
- `in_valid`, input, 1: `in_instr` is valid.
- `in_ready`, output, 1: the block can accept an input this cycle.
- `in_instr`, input, WIDTH: instruction word.
- `out_valid`, output, 1: decoded result is valid.
- `out_ready`, input, 1: the consumer accepts the result this cycle.
- `ALU_Sel`, output, 4: ALU select code.
- `use_imm`, output, 1: 1 selects the immediate as ALU operand B; 0 selects rs2.
- `illegal`, output, 1: the opcode or funct combination is not decodable.

## Operation
- Select codes:
  - 0000 add; 0001 sub; 0010 sll; 0011 srl; 0100 sra.
  - 0101 and; 0110 or; 0111 xor.
  - 1000 sltu; 1001 slt; 1010 pass B.
- Field sources: opcode = instr[6:0], f3 = instr[14:12], f7b = instr[30].
- OP (0110011), `use_imm`=0:
  - f3 000 → add if f7b=0, sub if f7b=1.
  - 001 → sll; 010 → slt; 011 → sltu; 100 → xor.
  - 101 → srl if f7b=0, sra if f7b=1.
  - 110 → or; 111 → and.
- OP-IMM (0010011), `use_imm`=1: same mapping as OP, with these exceptions:
  - f3 000 is always add.
  - f3 101 uses f7b to choose srl/sra.
- LOAD (0000011), STORE (0100011), JALR (1100111), AUIPC (0010111), JAL (1101111): add, `use_imm`=1.
- LUI (0110111): 1010 (pass B), `use_imm`=1.
- BRANCH (1100011), `use_imm`=0:
  - f3 000/001 → sub.
  - 100/101 → slt.
  - 110/111 → sltu.
  - 010/011 → `illegal`.
- Any other opcode → `illegal`=1, `ALU_Sel`=0000, `use_imm`=0.
- `illegal` entries are still transferred normally; they are never dropped.
- Decode is combinational on `in_instr`. The result is captured into the output register (OUT) or the skid register (SKID).
- Buffer state machine; "accept" = `in_valid` & `in_ready`, "send" = `out_valid` & `out_ready`:
  - EMPTY: `out_valid`=0, `in_ready`=1. Accept → OUT ← decode, go to ONE.
  - ONE: `out_valid`=1, `in_ready`=1.
    - Accept & send → OUT ← decode, stay in ONE.
    - Accept only → SKID ← decode, go to FULL.
    - Send only → go to EMPTY.
  - FULL: `out_valid`=1, `in_ready`=0. Send → OUT ← SKID, go to ONE.
- Outputs come straight from OUT. `in_ready` is a decode of the state register only; there is no combinational path from `out_ready` or `in_valid`.
- Order is strictly FIFO. Results are never duplicated or lost.
- `flush`=1: next state is EMPTY and OUT/SKID contents are discarded. A same-cycle accept is dropped and a same-cycle send is still considered consumed. `flush` has priority over all handshake events.
- `rst_n`=0 overrides `flush`.

## Timing
- Reset (`rst_n` low at an edge):
  - State becomes EMPTY.
  - `out_valid`=0, `ALU_Sel`=0000, `use_imm`=0, `illegal`=0.
  - `in_ready` is forced to 0 while `rst_n`=0 and is 1 on the first cycle after release.
- Reset mid-transfer discards both entries. No output is produced for them.
- Latency: an instruction accepted at edge N is presented with `out_valid`=1 in cycle N+1.
- Throughput: 1 instruction per cycle while `out_ready`=1.
- With `out_ready`=0, at most 2 entries are held; `in_ready` falls in the cycle after the second accept.
- Once `out_valid`=1, `ALU_Sel`, `use_imm` and `illegal` are held stable until a send.
- After `out_ready` returns high in FULL, `in_ready` is 1 in the next cycle.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0, `out_valid`=0, `ALU_Sel`=0000. After release, `in_ready`=1 and `out_valid`=0 until the first accept.
- Decode sweep with `out_ready`=1, checking the result one cycle after each input:
  - 0x40208033 (sub) → 0001, `use_imm`=0.
  - 0x4020D093 (srai) → 0100, `use_imm`=1.
  - 0x000020B7 (lui) → 1010, `use_imm`=1.
  - 0x0020C463 (blt) → 1001, `use_imm`=0.
  - 0x00000000 → `illegal`=1, 0000.
- Streaming: 8 back-to-back valid instructions with `out_ready`=1 → 8 outputs on consecutive cycles in order, with `in_ready` constantly 1.
- Backpressure: `out_ready`=0 while driving 3 instructions A, B, C → A and B accepted, `in_ready`=0 on the third cycle, C held. Then raise `out_ready` → outputs appear as A, B, C in order with none lost.
- Flush in FULL with `in_valid`=1 → next cycle `out_valid`=0, `in_ready`=1, and the flushed and same-cycle entries never appear on the output.
- Reset asserted in FULL → next cycle EMPTY with all outputs at reset values; the subsequent instruction decodes correctly with 1-cycle latency.

Source files
------------

// File: rtl/alu_op_decoder.sv
// rtl/alu_op_decoder.sv - RV32I ALU select decode stage with 2-entry skid buffer
module alu_op_decoder #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_instr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       ALU_Sel,
   output logic             use_imm,
   output logic             illegal
);

   localparam logic [3:0] SEL_ADD  = 4'b0000;
   localparam logic [3:0] SEL_SUB  = 4'b0001;
   localparam logic [3:0] SEL_SLL  = 4'b0010;
   localparam logic [3:0] SEL_SRL  = 4'b0011;
   localparam logic [3:0] SEL_SRA  = 4'b0100;
   localparam logic [3:0] SEL_AND  = 4'b0101;
   localparam logic [3:0] SEL_OR   = 4'b0110;
   localparam logic [3:0] SEL_XOR  = 4'b0111;
   localparam logic [3:0] SEL_SLTU = 4'b1000;
   localparam logic [3:0] SEL_SLT  = 4'b1001;
   localparam logic [3:0] SEL_PASS = 4'b1010;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t     state;
   logic [6:0] opcode;
   logic [2:0] f3;
   logic       f7b;
   logic [3:0] dec_sel;
   logic       dec_imm;
   logic       dec_ill;
   logic [3:0] out_sel;
   logic       out_imm;
   logic       out_ill;
   logic [3:0] skid_sel;
   logic       skid_imm;
   logic       skid_ill;
   logic       accept;
   logic       send;
   logic       unused_bits;

   assign opcode      = in_instr[6:0];
   assign f3          = in_instr[14:12];
   assign f7b         = in_instr[30];
   assign unused_bits = ^{in_instr[WIDTH-1:31], in_instr[29:15], in_instr[11:7]};

   // Combinational decode of the incoming instruction word
   always_comb begin
      dec_sel = SEL_ADD;
      dec_imm = 1'b0;
      dec_ill = 1'b0;
      case (opcode)
         7'b0110011, 7'b0010011: begin
            dec_imm = (opcode == 7'b0010011);
            case (f3)
               3'b000:  dec_sel = (f7b && !dec_imm) ? SEL_SUB : SEL_ADD;
               3'b001:  dec_sel = SEL_SLL;
               3'b010:  dec_sel = SEL_SLT;
               3'b011:  dec_sel = SEL_SLTU;
               3'b100:  dec_sel = SEL_XOR;
               3'b101:  dec_sel = f7b ? SEL_SRA : SEL_SRL;
               3'b110:  dec_sel = SEL_OR;
               default: dec_sel = SEL_AND;
            endcase
         end
         7'b0000011, 7'b0100011, 7'b1100111, 7'b0010111, 7'b1101111: begin
            dec_sel = SEL_ADD;
            dec_imm = 1'b1;
         end
         7'b0110111: begin
            dec_sel = SEL_PASS;
            dec_imm = 1'b1;
         end
         7'b1100011: begin
            case (f3[2:1])
               2'b00:   dec_sel = SEL_SUB;
               2'b10:   dec_sel = SEL_SLT;
               2'b11:   dec_sel = SEL_SLTU;
               default: dec_ill = 1'b1;
            endcase
         end
         default: dec_ill = 1'b1;
      endcase
   end

   // in_ready depends only on the state register, masked low while reset is held
   assign in_ready  = rst_n && (state != FULL);
   assign out_valid = (state != EMPTY);
   assign accept    = in_valid && in_ready;
   assign send      = out_valid && out_ready;
   assign ALU_Sel   = out_sel;
   assign use_imm   = out_imm;
   assign illegal   = out_ill;

   // Skid buffer state machine: OUT drives the outputs, SKID holds the second entry
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= EMPTY;
         out_sel  <= 4'b0000;
         out_imm  <= 1'b0;
         out_ill  <= 1'b0;
         skid_sel <= 4'b0000;
         skid_imm <= 1'b0;
         skid_ill <= 1'b0;
      end else if (flush) begin
         state <= EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  out_sel <= dec_sel;
                  out_imm <= dec_imm;
                  out_ill <= dec_ill;
                  state   <= ONE;
               end
            end
            ONE: begin
               if (accept && send) begin
                  out_sel <= dec_sel;
                  out_imm <= dec_imm;
                  out_ill <= dec_ill;
               end else if (accept) begin
                  skid_sel <= dec_sel;
                  skid_imm <= dec_imm;
                  skid_ill <= dec_ill;
                  state    <= FULL;
               end else if (send) begin
                  state <= EMPTY;
               end
            end
            FULL: begin
               if (send) begin
                  out_sel <= skid_sel;
                  out_imm <= skid_imm;
                  out_ill <= skid_ill;
                  state   <= ONE;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_decoder.sv
// tb/tb_alu_op_decoder.sv - self-checking bench for alu_op_decoder
module tb_alu_op_decoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  ALU_Sel;
   logic        use_imm;
   logic        illegal;

   int checks   = 0;
   int failures = 0;
   bit mon_en   = 1'b0;
   logic [5:0] exp_q [$];

   typedef struct {
      logic [31:0] instr;
      logic [3:0]  sel;
      logic        imm;
      logic        ill;
   } vec_t;

   vec_t tab [20];

   alu_op_decoder #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .out_valid(out_valid), .out_ready(out_ready),
      .ALU_Sel(ALU_Sel), .use_imm(use_imm), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference decode: {illegal, use_imm, sel}; sub/sra are the "alternate" of add/srl (code + 1)
   function automatic logic [5:0] ref_dec(input logic [31:0] i);
      logic [3:0] base [8];
      logic [3:0] br [4];
      int  f3;
      bit  alt;
      base = '{4'd0, 4'd2, 4'd9, 4'd8, 4'd7, 4'd3, 4'd6, 4'd5};
      br   = '{4'd1, 4'd0, 4'd9, 4'd8};
      f3   = int'(i[14:12]);
      alt  = i[30];
      case (i[6:0])
         7'b0110011: return {2'b00, base[f3] + 4'((alt && (f3 == 0 || f3 == 5)) ? 1 : 0)};
         7'b0010011: return {2'b01, base[f3] + 4'((alt && f3 == 5) ? 1 : 0)};
         7'b0000011, 7'b0100011, 7'b1100111, 7'b0010111, 7'b1101111: return {2'b01, 4'd0};
         7'b0110111: return {2'b01, 4'd10};
         7'b1100011: return (f3 / 2 == 1) ? 6'b10_0000 : {2'b00, br[f3 / 2]};
         default:    return 6'b10_0000;
      endcase
   endfunction

   // Queue model of the buffer, evaluated mid-cycle for the upcoming edge
   always @(negedge clk) begin
      if (mon_en) begin
         logic exp_rdy;
         exp_rdy = rst_n && (exp_q.size() < 2);
         chk("mon_in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
         chk("mon_out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
         if (exp_q.size() != 0)
            chk("mon_result", {26'd0, illegal, use_imm, ALU_Sel}, {26'd0, exp_q[0]});
         if (!rst_n || flush) begin
            exp_q.delete();
         end else begin
            if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
            if (in_valid && exp_rdy) exp_q.push_back(ref_dec(in_instr));
         end
      end
   end

   function automatic logic [31:0] rand_instr();
      logic [6:0] ops [10];
      logic [31:0] w;
      ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100111,
              7'b0010111, 7'b1101111, 7'b0110111, 7'b1100011, 7'b1111111};
      w = $urandom;
      if ($urandom_range(0, 3) != 0) w[6:0] = ops[$urandom_range(0, 9)];
      return w;
   endfunction

   initial begin
      tab[0]  = '{32'h40208033, 4'h1, 1'b0, 1'b0};
      tab[1]  = '{32'h4020D093, 4'h4, 1'b1, 1'b0};
      tab[2]  = '{32'h000020B7, 4'hA, 1'b1, 1'b0};
      tab[3]  = '{32'h0020C463, 4'h9, 1'b0, 1'b0};
      tab[4]  = '{32'h00000000, 4'h0, 1'b0, 1'b1};
      tab[5]  = '{32'h40000013, 4'h0, 1'b1, 1'b0};
      tab[6]  = '{32'h00007033, 4'h5, 1'b0, 1'b0};
      tab[7]  = '{32'h00003013, 4'h8, 1'b1, 1'b0};
      tab[8]  = '{32'h00002003, 4'h0, 1'b1, 1'b0};
      tab[9]  = '{32'h00002023, 4'h0, 1'b1, 1'b0};
      tab[10] = '{32'h0000006F, 4'h0, 1'b1, 1'b0};
      tab[11] = '{32'h00000017, 4'h0, 1'b1, 1'b0};
      tab[12] = '{32'h00000067, 4'h0, 1'b1, 1'b0};
      tab[13] = '{32'h00002063, 4'h0, 1'b0, 1'b1};
      tab[14] = '{32'h00007063, 4'h8, 1'b0, 1'b0};
      tab[15] = '{32'h00001063, 4'h1, 1'b0, 1'b0};
      tab[16] = '{32'h40005033, 4'h4, 1'b0, 1'b0};
      tab[17] = '{32'h00004013, 4'h7, 1'b1, 1'b0};
      tab[18] = '{32'h00001013, 4'h2, 1'b1, 1'b0};
      tab[19] = '{32'h0000007F, 4'h0, 1'b0, 1'b1};

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_instr = 32'h40208033; out_ready = 1'b1;

      // Reset held for 3 cycles with in_valid high
      for (int c = 0; c < 3; c++) begin
         tick();
         mon_en = 1'b1;
         chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
         chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
         chk("rst_alu_sel", {28'd0, ALU_Sel}, 32'd0);
      end
      rst_n = 1'b1; in_valid = 1'b0;
      #1;
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
      tick();
      chk("idle_out_valid", {31'd0, out_valid}, 32'd0);

      // Decode sweep, back-to-back with out_ready=1
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1;
         in_instr = tab[i].instr;
         tick();
         chk($sformatf("sweep%0d_valid", i), {31'd0, out_valid}, 32'd1);
         chk($sformatf("sweep%0d_ready", i), {31'd0, in_ready}, 32'd1);
         chk($sformatf("sweep%0d_sel", i), {28'd0, ALU_Sel}, {28'd0, tab[i].sel});
         chk($sformatf("sweep%0d_imm", i), {31'd0, use_imm}, {31'd0, tab[i].imm});
         chk($sformatf("sweep%0d_ill", i), {31'd0, illegal}, {31'd0, tab[i].ill});
      end
      in_valid = 1'b0;
      tick();
      chk("sweep_drain", {31'd0, out_valid}, 32'd0);

      // Backpressure: A (sub), B (and), C (lui)
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'h40208033;
      tick();
      chk("bp_ready_after_a", {31'd0, in_ready}, 32'd1);
      in_instr = 32'h00007033;
      tick();
      chk("bp_ready_after_b", {31'd0, in_ready}, 32'd0);
      in_instr = 32'h000020B7;
      tick();
      chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_hold_a", {28'd0, ALU_Sel}, 32'h1);
      out_ready = 1'b1;
      tick();
      chk("bp_out_b", {28'd0, ALU_Sel}, 32'h5);
      chk("bp_ready_back", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      chk("bp_out_c", {28'd0, ALU_Sel}, 32'hA);
      chk("bp_out_c_valid", {31'd0, out_valid}, 32'd1);
      tick();
      chk("bp_empty", {31'd0, out_valid}, 32'd0);

      // Flush while FULL with a same-cycle input
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'h00004013;
      tick();
      in_instr = 32'h00001013;
      tick();
      flush = 1'b1; in_instr = 32'h000020B7;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b1;
      tick();
      tick();
      chk("flush_nothing_out", {31'd0, out_valid}, 32'd0);

      // Reset while FULL, then a fresh instruction
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'h40005033;
      tick();
      in_instr = 32'h00007063;
      tick();
      rst_n = 1'b0;
      tick();
      chk("rfull_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rfull_alu_sel", {28'd0, ALU_Sel}, 32'd0);
      chk("rfull_use_imm", {31'd0, use_imm}, 32'd0);
      chk("rfull_illegal", {31'd0, illegal}, 32'd0);
      chk("rfull_in_ready", {31'd0, in_ready}, 32'd0);
      rst_n = 1'b1; in_instr = 32'h4020D093; out_ready = 1'b1;
      #1;
      chk("rfull_ready_release", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      chk("rfull_next_valid", {31'd0, out_valid}, 32'd1);
      chk("rfull_next_sel", {28'd0, ALU_Sel}, 32'h4);
      chk("rfull_next_imm", {31'd0, use_imm}, 32'd1);
      tick();

      // Randomized traffic against the queue model
      for (int c = 0; c < 600; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_instr  = rand_instr();
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 31) == 0);
         rst_n     = ($urandom_range(0, 63) != 0);
         tick();
      end
      rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (4) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
